cfu_conv_sequencer: RTL
=======================

CFU_CONV_SEQUENCER -- requirements
Module: cfu_conv_sequencer

Interface
REQ-001 SHALL have parameter MAX_WORDS, default 256, meaning the largest input/output length in 32-bit words (1024 bytes).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning the response-wait limit used by the watchdog.
REQ-003 SHALL have ports, one per line, as follows.
- clk  in  1  clock.
- reset  in  1  reset; synchronous, active-high.
- start  in  1  pulse that begins a sequence.
- buffer_size  in  32  length in bytes; sampled at start.
- bias  in  32  bias value; sampled at start.
- kernel_w0, kernel_w1  in  32 each  packed kernel bytes; sampled at start.
- in_rd_en  out  1  input-memory read strobe.
- in_rd_addr  out  8  input-memory word address.
- in_rd_data  in  32  read data, valid the cycle after in_rd_en.
- out_wr_en  out  1  result write strobe.
- out_wr_addr  out  8  result word address.
- out_wr_data  out  32  result word.
- cmd_valid  out  1  CFU command valid.
- cmd_ready  in  1  CFU command ready.
- cmd_payload_function_id  out  10  {funct7, 3'b000}.
- cmd_payload_inputs_0, cmd_payload_inputs_1  out  32 each  CFU operands.
- rsp_valid  in  1  CFU response valid.
- rsp_ready  out  1  CFU response ready.
- rsp_payload_outputs_0  in  32  CFU response data.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky error flag; cleared by the next accepted start.

Function
REQ-004 SHALL treat start as accepted only in IDLE; start while busy SHALL be ignored.
REQ-005 SHALL reject an accepted start with buffer_size = 0, buffer_size > 4*MAX_WORDS, or buffer_size not a multiple of 8: go to ERR, issue no command.
REQ-006 SHALL issue commands in this phase order, with N = buffer_size/4:
- INIT funct7=0.
- INPUT funct7=1, N commands, inputs_0=i, inputs_1=word i.
- KERNEL funct7=2, 2 commands, inputs_0=0/1, inputs_1=kernel_w0/w1.
- BIAS funct7=8, inputs_0=bias.
- SIZE funct7=4, inputs_0=buffer_size.
- START funct7=5.
- READ funct7=3, N commands, inputs_0=i.
REQ-007 SHALL use states IDLE, FETCH, LATCH, ISSUE, WAIT_RSP, DONE, ERR, plus a phase register.
REQ-008 SHALL make FETCH (INPUT phase only) assert in_rd_en for one cycle with in_rd_addr=i; LATCH captures in_rd_data; then ISSUE.
REQ-009 SHALL hold cmd_valid and all payloads stable in ISSUE until the cycle cmd_valid&&cmd_ready, then enter WAIT_RSP.
REQ-010 SHALL drive rsp_ready=1 only in WAIT_RSP; rsp_valid in other states SHALL be ignored.
REQ-011 SHALL keep at most one command outstanding; the next command issues no earlier than the cycle after the rsp handshake.
REQ-012 SHALL, on each READ-phase rsp handshake, pulse out_wr_en in the following cycle with out_wr_addr=i and out_wr_data=rsp_payload_outputs_0; responses in other phases are discarded.
REQ-013 SHALL keep the START-phase wait unbounded in cycle count, since the responder withholds rsp_valid until compute ends (subject to REQ-017).
REQ-014 SHALL, after the last READ response, enter DONE (done=1 for one cycle), then IDLE; busy=1 in every state except IDLE.
REQ-015 SHALL exit ERR only on an accepted start.

Reset
REQ-016 SHALL, on reset, drive state=IDLE and deassert cmd_valid, rsp_ready, in_rd_en, out_wr_en, busy, done and error, with all payloads 0; reset mid-sequence abandons it with no further commands.

Configuration
REQ-017 SHALL, with CFU_SEQ_TIMEOUT_EN defined, count cycles in ISSUE+WAIT_RSP per command; on reaching TIMEOUT_CYCLES, deassert cmd_valid/rsp_ready, set error and go to ERR.
REQ-018 SHALL, without CFU_SEQ_TIMEOUT_EN, contain no counter and wait indefinitely.

Structure
REQ-019 SHALL place the funct7 constants (INIT, WR_IN, WR_K, RD_OUT, SET_SIZE, START, SET_BIAS), the state and phase enums, and MAX_WORDS in package cfu_seq_pkg.
REQ-020 SHALL isolate the command/response handshake holding registers in sub-module cfu_cmd_port.

Verification
REQ-021 SHALL verify a full sequence: buffer_size=8, words 0x07060504/0x03020100, kernels 0x02020202, bias=1, responder model cmd_ready=~rsp_valid with a 1-cycle response. Required function_id trace: 0x000, 0x008, 0x008, 0x010, 0x010, 0x040, 0x020, 0x028, 0x018, 0x018. Then done pulse, busy=0.
REQ-022 SHALL verify READ results: model returns 0xA0000000+i; expect out_wr_addr/data 0/0xA0000000 and 1/0xA0000001 only, with no other out_wr_en.
REQ-023 SHALL verify backpressure: cmd_ready held 0 for 5 cycles at the BIAS command -> cmd_valid stays high, payload 0x00000001 unchanged, single handshake.
REQ-024 SHALL verify bad size: buffer_size=12 -> error=1 next cycle, cmd_valid never asserted, and a following start with size 16 clears error.
REQ-025 SHALL verify START delay and timeout: START response delayed 20 cycles -> rsp_ready high throughout, sequence completes. With CFU_SEQ_TIMEOUT_EN and TIMEOUT_CYCLES=16, the same stimulus -> error=1 and state ERR.
REQ-026 SHALL verify reset mid-sequence: reset during the INPUT phase -> all outputs 0 the next cycle and no further commands issued.

Source files
------------

// File: rtl/cfu_seq_pkg.sv
// Shared definitions for the CFU convolution sequencer: CFU funct7 opcodes,
// controller state and command-phase encodings, and the default buffer limit.
package cfu_seq_pkg;

    localparam int MAX_WORDS = 256;
    localparam int FID_W     = 10;

    localparam logic [6:0] F7_INIT     = 7'd0;
    localparam logic [6:0] F7_WR_IN    = 7'd1;
    localparam logic [6:0] F7_WR_K     = 7'd2;
    localparam logic [6:0] F7_RD_OUT   = 7'd3;
    localparam logic [6:0] F7_SET_SIZE = 7'd4;
    localparam logic [6:0] F7_START    = 7'd5;
    localparam logic [6:0] F7_SET_BIAS = 7'd8;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        ISSUE,
        WAIT_RSP,
        DONE,
        ERR
    } seq_state_t;

    typedef enum logic [2:0] {
        PH_INIT,
        PH_INPUT,
        PH_KERNEL,
        PH_BIAS,
        PH_SIZE,
        PH_START,
        PH_READ
    } seq_phase_t;

    // The CFU bus carries funct7 in the upper bits with funct3 fixed at zero.
    function automatic logic [FID_W-1:0] function_id(input logic [6:0] funct7);
        return {funct7, 3'b000};
    endfunction

endpackage

// File: rtl/cfu_cmd_port.sv
// Holding registers for the CFU command/response handshake: one command is
// loaded, held until accepted, then the port waits for exactly one response.
module cfu_cmd_port
    import cfu_seq_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             abort,
    input  logic             load,
    input  logic [FID_W-1:0] load_function_id,
    input  logic [31:0]      load_inputs_0,
    input  logic [31:0]      load_inputs_1,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [FID_W-1:0] cmd_payload_function_id,
    output logic [31:0]      cmd_payload_inputs_0,
    output logic [31:0]      cmd_payload_inputs_1,
    input  logic             rsp_valid,
    output logic             rsp_ready,
    output logic             cmd_fire,
    output logic             rsp_fire
);

    assign cmd_fire = cmd_valid && cmd_ready;
    assign rsp_fire = rsp_ready && rsp_valid;

    // A load may coincide with the previous response handshake; the new
    // command then becomes valid the following cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cmd_valid               <= 1'b0;
            rsp_ready               <= 1'b0;
            cmd_payload_function_id <= '0;
            cmd_payload_inputs_0    <= '0;
            cmd_payload_inputs_1    <= '0;
        end else if (abort) begin
            cmd_valid <= 1'b0;
            rsp_ready <= 1'b0;
        end else begin
            if (load) begin
                cmd_valid               <= 1'b1;
                cmd_payload_function_id <= load_function_id;
                cmd_payload_inputs_0    <= load_inputs_0;
                cmd_payload_inputs_1    <= load_inputs_1;
            end else if (cmd_fire) begin
                cmd_valid <= 1'b0;
                rsp_ready <= 1'b1;
            end
            if (rsp_fire) begin
                rsp_ready <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cfu_conv_sequencer.sv
// Drives a CFU convolution accelerator through INIT/INPUT/KERNEL/BIAS/SIZE/
// START/READ command phases. Define CFU_SEQ_TIMEOUT_EN to enable the watchdog.
module cfu_conv_sequencer #(
    parameter int MAX_WORDS      = cfu_seq_pkg::MAX_WORDS,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] buffer_size,
    input  logic [31:0] bias,
    input  logic [31:0] kernel_w0,
    input  logic [31:0] kernel_w1,
    output logic        in_rd_en,
    output logic [7:0]  in_rd_addr,
    input  logic [31:0] in_rd_data,
    output logic        out_wr_en,
    output logic [7:0]  out_wr_addr,
    output logic [31:0] out_wr_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    output logic [9:0]  cmd_payload_function_id,
    output logic [31:0] cmd_payload_inputs_0,
    output logic [31:0] cmd_payload_inputs_1,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    input  logic [31:0] rsp_payload_outputs_0,
    output logic        busy,
    output logic        done,
    output logic        error
);

    import cfu_seq_pkg::*;

    localparam int IDX_W = $clog2(MAX_WORDS + 1);

    seq_state_t       state, state_next;
    seq_phase_t       phase, phase_next;
    logic [IDX_W-1:0] idx, idx_next;

    logic [31:0] size_q, bias_q, k0_q, k1_q;
    logic        size_bad, last_word;
    logic        accept, wr_fire, abort, timed_out;
    logic        load, cmd_fire, rsp_fire;
    logic [6:0]  load_f7;
    logic [31:0] load_in0, load_in1;

    assign size_bad  = (buffer_size == 32'd0) || (buffer_size > 32'(4 * MAX_WORDS))
                       || (buffer_size[2:0] != 3'd0);
    assign last_word = ((32'(idx) + 32'd1) << 2) == size_q;

    assign busy       = (state != IDLE);
    assign done       = (state == DONE);
    assign in_rd_en   = (state == FETCH);
    assign in_rd_addr = 8'(idx);

    cfu_cmd_port u_cmd_port (
        .clk                     (clk),
        .reset                   (reset),
        .abort                   (abort),
        .load                    (load),
        .load_function_id        (function_id(load_f7)),
        .load_inputs_0           (load_in0),
        .load_inputs_1           (load_in1),
        .cmd_valid               (cmd_valid),
        .cmd_ready               (cmd_ready),
        .cmd_payload_function_id (cmd_payload_function_id),
        .cmd_payload_inputs_0    (cmd_payload_inputs_0),
        .cmd_payload_inputs_1    (cmd_payload_inputs_1),
        .rsp_valid               (rsp_valid),
        .rsp_ready               (rsp_ready),
        .cmd_fire                (cmd_fire),
        .rsp_fire                (rsp_fire)
    );

`ifdef CFU_SEQ_TIMEOUT_EN
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TO_W-1:0] wd_count;

    // Restarted for every command so only a single stalled exchange trips it.
    always_ff @(posedge clk) begin
        if (reset || load) begin
            wd_count <= '0;
        end else if (state == ISSUE || state == WAIT_RSP) begin
            wd_count <= wd_count + 1'b1;
        end
    end

    assign timed_out = (state == ISSUE || state == WAIT_RSP)
                       && (wd_count == TO_W'(TIMEOUT_CYCLES - 1));
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            phase <= PH_INIT;
            idx   <= '0;
        end else begin
            state <= state_next;
            phase <= phase_next;
            idx   <= idx_next;
        end
    end

    // Each command is loaded into the port on the transition into ISSUE.
    always_comb begin
        state_next = state;
        phase_next = phase;
        idx_next   = idx;
        load       = 1'b0;
        load_f7    = F7_INIT;
        load_in0   = 32'd0;
        load_in1   = 32'd0;
        accept     = 1'b0;
        wr_fire    = 1'b0;
        abort      = 1'b0;

        case (state)
            IDLE, ERR: begin
                if (start) begin
                    accept = 1'b1;
                    if (size_bad) begin
                        state_next = ERR;
                    end else begin
                        phase_next = PH_INIT;
                        idx_next   = '0;
                        load       = 1'b1;
                        load_f7    = F7_INIT;
                        state_next = ISSUE;
                    end
                end
            end
            FETCH: begin
                state_next = LATCH;
            end
            LATCH: begin
                load       = 1'b1;
                load_f7    = F7_WR_IN;
                load_in0   = 32'(idx);
                load_in1   = in_rd_data;
                state_next = ISSUE;
            end
            ISSUE: begin
                if (cmd_fire) begin
                    state_next = WAIT_RSP;
                end else if (timed_out) begin
                    abort      = 1'b1;
                    state_next = ERR;
                end
            end
            WAIT_RSP: begin
                if (rsp_fire) begin
                    state_next = ISSUE;
                    case (phase)
                        PH_INIT: begin
                            phase_next = PH_INPUT;
                            idx_next   = '0;
                            state_next = FETCH;
                        end
                        PH_INPUT: begin
                            if (last_word) begin
                                phase_next = PH_KERNEL;
                                idx_next   = '0;
                                load       = 1'b1;
                                load_f7    = F7_WR_K;
                                load_in1   = k0_q;
                            end else begin
                                idx_next   = idx + 1'b1;
                                state_next = FETCH;
                            end
                        end
                        PH_KERNEL: begin
                            load = 1'b1;
                            if (idx == '0) begin
                                idx_next = IDX_W'(1);
                                load_f7  = F7_WR_K;
                                load_in0 = 32'd1;
                                load_in1 = k1_q;
                            end else begin
                                phase_next = PH_BIAS;
                                load_f7    = F7_SET_BIAS;
                                load_in0   = bias_q;
                            end
                        end
                        PH_BIAS: begin
                            phase_next = PH_SIZE;
                            load       = 1'b1;
                            load_f7    = F7_SET_SIZE;
                            load_in0   = size_q;
                        end
                        PH_SIZE: begin
                            phase_next = PH_START;
                            load       = 1'b1;
                            load_f7    = F7_START;
                        end
                        PH_START: begin
                            phase_next = PH_READ;
                            idx_next   = '0;
                            load       = 1'b1;
                            load_f7    = F7_RD_OUT;
                        end
                        PH_READ: begin
                            wr_fire = 1'b1;
                            if (last_word) begin
                                state_next = DONE;
                            end else begin
                                idx_next = idx + 1'b1;
                                load     = 1'b1;
                                load_f7  = F7_RD_OUT;
                                load_in0 = 32'(idx) + 32'd1;
                            end
                        end
                        default: begin
                            state_next = IDLE;
                        end
                    endcase
                end else if (timed_out) begin
                    abort      = 1'b1;
                    state_next = ERR;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operands are captured at start; error is cleared by any accepted start.
    always_ff @(posedge clk) begin
        if (reset) begin
            size_q      <= '0;
            bias_q      <= '0;
            k0_q        <= '0;
            k1_q        <= '0;
            error       <= 1'b0;
            out_wr_en   <= 1'b0;
            out_wr_addr <= '0;
            out_wr_data <= '0;
        end else begin
            if (accept) begin
                size_q <= buffer_size;
                bias_q <= bias;
                k0_q   <= kernel_w0;
                k1_q   <= kernel_w1;
                error  <= size_bad;
            end else if (abort) begin
                error <= 1'b1;
            end
            out_wr_en <= wr_fire;
            if (wr_fire) begin
                out_wr_addr <= 8'(idx);
                out_wr_data <= rsp_payload_outputs_0;
            end
        end
    end

endmodule
